ysyx_23060072_lsu: RTL
======================

YSYX_23060072_LSU -- requirements
Module: ysyx_23060072_lsu

Interface
REQ-001 Parameter: none; the data path is fixed at 32 bits, and register addresses are 5 bits.
REQ-002 clk  in  1  single clock, rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 ex2lsu_valid  in  1  EX/LSU register holds a live instruction.
REQ-005 ex2lsu_load_flag / ex2lsu_store_flag  in  1 each  instruction is a load / a store (never both).
REQ-006 ex2lsu_funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 ex2lsu_wb_flag  in  1  instruction writes rd.
REQ-008 ex2lsu_wb_addr  in  5  rd.
REQ-009 ex2lsu_wb_data_ex  in  32  ALU result; this is the effective address for loads and stores.
REQ-010 operand_b_lsu_stage  in  32  store data, already forwarded.
REQ-011 lsu_stall  out  1  hold the EX/LSU register and the upstream stages (combinational).
REQ-012 mem_req_valid  out  1, mem_req_ready  in  1  request handshake.
REQ-013 mem_addr  out  32  word-aligned address {addr[31:2],2'b00}.
REQ-014 mem_wen  out  1, mem_wdata  out  32, mem_wstrb  out  4  write controls.
REQ-015 mem_rsp_valid  in  1, mem_rdata  in  32  response; a store's response is a write acknowledge.
REQ-016 lsu2wb_valid, lsu2wb_wb_flag, lsu2wb_load_flag  out  1 each; lsu2wb_wb_addr  out  5; lsu2wb_wb_data_lsu  out  32  LSU/WB register.
REQ-017 lsu_err  out  1  one-cycle pulse, registered with lsu2wb, for a misaligned access or illegal funct3.

Function
REQ-018 The FSM states shall be IDLE, REQ and WAIT.
- IDLE: on ex2lsu_valid & (load|store) & !err, capture addr, mem_wen, wdata and wstrb into internal registers, then go to REQ.
- REQ: hold mem_req_valid=1; on mem_req_ready go to WAIT.
- WAIT: on mem_rsp_valid go to IDLE.
REQ-019 mem_req_valid shall be 1 only in REQ; mem_addr, mem_wen, mem_wdata and mem_wstrb shall come from the captured registers and stay stable while mem_req_valid=1 && !mem_req_ready.
REQ-020 lsu_stall = ex2lsu_valid & (load|store) & !err & !(state==WAIT & mem_rsp_valid).
REQ-021 Non-memory instruction: ex2lsu fields are registered into lsu2wb on the next edge (1-cycle latency); lsu2wb_wb_data_lsu = ex2lsu_wb_data_ex; no stall.
REQ-022 Memory instruction: lsu2wb is loaded on the edge where WAIT & mem_rsp_valid. Minimum latency is 3 cycles (IDLE, REQ, WAIT).
REQ-023 The store data shall be captured in the IDLE cycle, so a forwarded load-to-store value survives later LSU/WB bubbles.
REQ-024 Store formatting:
- SB: wdata = byte replicated x4; wstrb = 4'b0001<<addr[1:0].
- SH: wdata = half replicated x2; wstrb = 4'b0011<<addr[1:0].
- SW: wstrb = 4'b1111.
REQ-025 Load extraction: select the lane by addr[1:0].
- B / H: sign-extend.
- BU / HU: zero-extend.
- W: pass through.
REQ-026 Error condition: H/HU with addr[0]=1, W with addr[1:0]!=0, or funct3 in {011,110,111}.
- No memory request is issued and there is no stall.
- The next edge gives lsu2wb_valid=1, lsu2wb_wb_flag=0, lsu_err=1.
REQ-027 On every edge where lsu2wb is not loaded, lsu2wb_valid, lsu2wb_wb_flag, lsu2wb_load_flag and lsu_err shall be 0 (bubble); lsu2wb_wb_addr and lsu2wb_wb_data_lsu shall hold their values.
REQ-028 lsu2wb_load_flag=1 only for a completed load, and lsu2wb_wb_flag follows ex2lsu_wb_flag; a store shall give lsu2wb_wb_flag=0.
REQ-029 lsu2wb_wb_addr=0 shall pass through unchanged; the forwarding and register file ignore x0.
REQ-030 mem_rsp_valid shall be ignored in IDLE and REQ; mem_req_ready shall be ignored outside REQ.
REQ-031 Response in the same cycle as a new non-memory instruction: not possible, because ex2lsu is held by the stall until the completing edge.

Reset
REQ-032 While rst=1 and asynchronously:
- state=IDLE.
- mem_req_valid=0.
- All lsu2wb outputs, lsu_err and the captured registers are 0.
REQ-033 Reset mid-transaction (REQ or WAIT) shall abandon the access; no lsu2wb_valid is produced for it, and a late mem_rsp_valid after reset is ignored.

Verification
REQ-034 ALU op, wb_addr=5, wb_data=0x12345678 -> next cycle lsu2wb_valid=1, wb_flag=1, wb_data_lsu=0x12345678, lsu_stall never asserted.
REQ-035 LB addr=0x103, rdata=0x80FF_FF_FF, ready and rsp each 1 cycle -> mem_addr=0x100, wen=0, stall for 3 cycles, then wb_data_lsu=0xFFFFFF80 and load_flag=1; LBU -> 0x00000080.
REQ-036 SH addr=0x202, operand_b=0x0000ABCD, mem_req_ready low for 4 cycles -> mem_addr=0x200, wstrb=1100, wdata=0xABCDABCD, all stable over the wait, then lsu2wb_valid=1 with wb_flag=0.
REQ-037 LW addr=0x301 -> no mem_req_valid, no stall, next cycle lsu_err=1, lsu2wb_valid=1, wb_flag=0.
REQ-038 SW captured with operand_b=0xDEADBEEF, operand_b changed to 0 after capture -> mem_wdata=0xDEADBEEF.
REQ-039 Assert rst while in WAIT -> mem_req_valid=0 and state IDLE immediately; a following rsp_valid pulse produces no lsu2wb_valid.

Source files
------------

// File: rtl/ysyx_23060072_lsu_if.sv
// Memory-side bus between the LSU and the data memory: one request channel, one response channel.
interface ysyx_23060072_lsu_if;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;

    // LSU side: issues requests, consumes responses
    modport master (
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb,
        input  mem_req_ready, mem_rsp_valid, mem_rdata
    );

    // Memory side: accepts requests, returns responses
    modport slave (
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb,
        output mem_req_ready, mem_rsp_valid, mem_rdata
    );
endinterface

// File: rtl/ysyx_23060072_lsu.sv
// Load/store unit: one outstanding memory access, stalls the pipe until it completes,
// passes non-memory instructions straight into the LSU/WB register.
module ysyx_23060072_lsu (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ex2lsu_valid,
    input  logic                       ex2lsu_load_flag,
    input  logic                       ex2lsu_store_flag,
    input  logic [2:0]                 ex2lsu_funct3,
    input  logic                       ex2lsu_wb_flag,
    input  logic [4:0]                 ex2lsu_wb_addr,
    input  logic [31:0]                ex2lsu_wb_data_ex,
    input  logic [31:0]                operand_b_lsu_stage,
    output logic                       lsu_stall,
    ysyx_23060072_lsu_if.master        mem,
    output logic                       lsu2wb_valid,
    output logic                       lsu2wb_wb_flag,
    output logic                       lsu2wb_load_flag,
    output logic [4:0]                 lsu2wb_wb_addr,
    output logic [31:0]                lsu2wb_wb_data_lsu,
    output logic                       lsu_err
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned RW   = 5;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]      state_q, state_d;
    logic            capture_en, load_mem, load_direct;

    logic            mem_op, f3_illegal, misalign, acc_err, mem_go, rsp_done;
    logic [XLEN-1:0] st_wdata;
    logic [3:0]      st_wstrb;

    logic [XLEN-3:0] addr_q;
    logic [1:0]      off_q;
    logic            wen_q;
    logic [XLEN-1:0] wdata_q;
    logic [3:0]      wstrb_q;
    logic [2:0]      f3_q;
    logic            load_q;
    logic            wb_flag_q;
    logic [RW-1:0]   wb_addr_q;

    logic [XLEN-1:0] ld_shift, ld_data;

    // Access classification and stall request
    always_comb begin
        mem_op     = ex2lsu_valid & (ex2lsu_load_flag | ex2lsu_store_flag);
        f3_illegal = (ex2lsu_funct3 == 3'b011) | (ex2lsu_funct3[2:1] == 2'b11);
        misalign   = ((ex2lsu_funct3[1:0] == 2'b01) & ex2lsu_wb_data_ex[0]) |
                     ((ex2lsu_funct3[1:0] == 2'b10) & (ex2lsu_wb_data_ex[1:0] != 2'b00));
        acc_err    = mem_op & (f3_illegal | misalign);
        mem_go     = mem_op & ~acc_err;
        rsp_done   = (state_q == S_WAIT) & mem.mem_rsp_valid;
        lsu_stall  = mem_go & ~rsp_done;
    end

    // Store lane formatting from the live EX/LSU fields
    always_comb begin
        st_wdata = operand_b_lsu_stage;
        st_wstrb = 4'b1111;
        case (ex2lsu_funct3[1:0])
            2'b00: begin
                st_wdata = {4{operand_b_lsu_stage[7:0]}};
                st_wstrb = 4'b0001 << ex2lsu_wb_data_ex[1:0];
            end
            2'b01: begin
                st_wdata = {2{operand_b_lsu_stage[15:0]}};
                st_wstrb = 4'b0011 << ex2lsu_wb_data_ex[1:0];
            end
            default: ;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next state and per-cycle control strobes
    always_comb begin
        state_d     = state_q;
        capture_en  = 1'b0;
        load_mem    = 1'b0;
        load_direct = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_go) begin
                    capture_en = 1'b1;
                    state_d    = S_REQ;
                end else if (ex2lsu_valid) begin
                    load_direct = 1'b1;
                end
            end
            S_REQ: begin
                if (mem.mem_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem.mem_rsp_valid) begin
                    load_mem = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Capture the access in IDLE so later operand changes cannot disturb it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q    <= '0;
            off_q     <= '0;
            wen_q     <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            f3_q      <= '0;
            load_q    <= 1'b0;
            wb_flag_q <= 1'b0;
            wb_addr_q <= '0;
        end else if (capture_en) begin
            addr_q    <= ex2lsu_wb_data_ex[XLEN-1:2];
            off_q     <= ex2lsu_wb_data_ex[1:0];
            wen_q     <= ex2lsu_store_flag;
            wdata_q   <= st_wdata;
            wstrb_q   <= st_wstrb;
            f3_q      <= ex2lsu_funct3;
            load_q    <= ex2lsu_load_flag;
            wb_flag_q <= ex2lsu_wb_flag;
            wb_addr_q <= ex2lsu_wb_addr;
        end
    end

    assign mem.mem_req_valid = (state_q == S_REQ);
    assign mem.mem_addr      = {addr_q, 2'b00};
    assign mem.mem_wen       = wen_q;
    assign mem.mem_wdata     = wdata_q;
    assign mem.mem_wstrb     = wstrb_q;

    // Load lane select and sign/zero extension
    always_comb begin
        ld_shift = mem.mem_rdata >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b100:  ld_data = {24'd0, ld_shift[7:0]};
            3'b101:  ld_data = {16'd0, ld_shift[15:0]};
            default: ld_data = ld_shift;
        endcase
    end

    // LSU/WB register: flags bubble by default, address/data hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lsu2wb_valid       <= 1'b0;
            lsu2wb_wb_flag     <= 1'b0;
            lsu2wb_load_flag   <= 1'b0;
            lsu2wb_wb_addr     <= '0;
            lsu2wb_wb_data_lsu <= '0;
            lsu_err            <= 1'b0;
        end else begin
            lsu2wb_valid     <= 1'b0;
            lsu2wb_wb_flag   <= 1'b0;
            lsu2wb_load_flag <= 1'b0;
            lsu_err          <= 1'b0;
            if (load_direct) begin
                lsu2wb_valid       <= 1'b1;
                lsu2wb_wb_flag     <= ex2lsu_wb_flag & ~acc_err;
                lsu_err            <= acc_err;
                lsu2wb_wb_addr     <= ex2lsu_wb_addr;
                lsu2wb_wb_data_lsu <= ex2lsu_wb_data_ex;
            end else if (load_mem) begin
                lsu2wb_valid     <= 1'b1;
                lsu2wb_wb_flag   <= wb_flag_q & load_q;
                lsu2wb_load_flag <= load_q;
                lsu2wb_wb_addr   <= wb_addr_q;
                if (load_q) lsu2wb_wb_data_lsu <= ld_data;
            end
        end
    end

endmodule
